// File: rtl/hazard_pkg.sv
// Shared types for the N-lane hazard / scoreboard unit.
// Forward select bundle, stage codes and issue FSM states.
package hazard_pkg;

    localparam int MAX_LANE_W = 4;

    localparam logic FWD_STAGE_M = 1'b0;
    localparam logic FWD_STAGE_W = 1'b1;

    typedef struct packed {
        logic                  valid;
        logic                  stage;
        logic [MAX_LANE_W-1:0] lane;
    } fwd_sel_t;

    typedef enum logic {
        S_FULL = 1'b0,
        S_PART = 1'b1
    } fsm_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward source priority encoder for one E-lane operand.
// M beats W; inside a stage the youngest writing lane wins.
import hazard_pkg::*;

module hazard_fwd_sel #(
    parameter int NUM_LANES = 2
) (
    input  logic [4:0]             rs_i,
    input  logic [NUM_LANES*5-1:0] m_rd_i,
    input  logic [NUM_LANES-1:0]   m_regwrite_i,
    input  logic [NUM_LANES*5-1:0] w_rd_i,
    input  logic [NUM_LANES-1:0]   w_regwrite_i,
    output fwd_sel_t               sel_o
);

    // W scanned first so any M hit overrides; later lanes override older ones
    always_comb begin
        sel_o = '0;
        if (rs_i != 5'd0) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_regwrite_i[i] && w_rd_i[i*5 +: 5] == rs_i) begin
                    sel_o.valid = 1'b1;
                    sel_o.stage = FWD_STAGE_W;
                    sel_o.lane  = MAX_LANE_W'(i);
                end
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                if (m_regwrite_i[i] && m_rd_i[i*5 +: 5] == rs_i) begin
                    sel_o.valid = 1'b1;
                    sel_o.stage = FWD_STAGE_M;
                    sel_o.lane  = MAX_LANE_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard_nlane.sv
// N-lane hazard unit: forwarding, load-use, long-op scoreboard,
// intra-bundle RAW split issue and E-stage redirect handling.
import hazard_pkg::*;

module hazard_scoreboard_nlane #(
    parameter int NUM_LANES = 2,
    parameter int MAX_LONG  = 4,
    parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [NUM_LANES-1:0]            d_valid_i,
    input  logic [NUM_LANES*5-1:0]          d_rs1_i,
    input  logic [NUM_LANES*5-1:0]          d_rs2_i,
    input  logic [NUM_LANES*5-1:0]          d_rd_i,
    input  logic [NUM_LANES-1:0]            d_regwrite_i,
    input  logic [NUM_LANES-1:0]            d_long_i,
    input  logic [NUM_LANES*5-1:0]          e_rs1_i,
    input  logic [NUM_LANES*5-1:0]          e_rs2_i,
    input  logic [NUM_LANES*5-1:0]          e_rd_i,
    input  logic [NUM_LANES-1:0]            e_regwrite_i,
    input  logic [NUM_LANES-1:0]            e_load_i,
    input  logic [NUM_LANES-1:0]            e_long_i,
    input  logic [NUM_LANES*5-1:0]          m_rd_i,
    input  logic [NUM_LANES*5-1:0]          w_rd_i,
    input  logic [NUM_LANES-1:0]            m_regwrite_i,
    input  logic [NUM_LANES-1:0]            w_regwrite_i,
    input  logic [NUM_LANES-1:0]            redirect_e_i,
    input  logic                            long_wb_valid_i,
    input  logic [4:0]                      long_wb_rd_i,
    output logic [NUM_LANES*(2+LANE_W)-1:0] fwd_a_o,
    output logic [NUM_LANES*(2+LANE_W)-1:0] fwd_b_o,
    output logic [NUM_LANES-1:0]            issue_mask_o,
    output logic                            stall_f_o,
    output logic                            stall_d_o,
    output logic                            flush_d_o,
    output logic [NUM_LANES-1:0]            flush_e_o,
    output logic [NUM_LANES-1:0]            flush_e_lane_o
);

    localparam int FW    = 2 + LANE_W;
    localparam int CNT_W = $clog2(MAX_LONG + 1);

    fsm_e                 state_q, state_n;
    logic [NUM_LANES-1:0] done_q, done_n;
    logic [31:0]          busy_q, busy_n;
    logic [CNT_W-1:0]     outst_q, outst_n;

    logic                 redir;
    logic [NUM_LANES-1:0] kill;
    logic [NUM_LANES-1:0] pending;
    logic [NUM_LANES-1:0] blocked;
    logic [NUM_LANES-1:0] long_lane;
    logic [NUM_LANES-1:0] issue;
    logic                 stall;
    logic [31:0]          wb_clr;
    logic [31:0]          busy_vis;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        fwd_sel_t sel_a;
        fwd_sel_t sel_b;

        hazard_fwd_sel #(.NUM_LANES(NUM_LANES)) u_fwd_a (
            .rs_i         (e_rs1_i[l*5 +: 5]),
            .m_rd_i       (m_rd_i),
            .m_regwrite_i (m_regwrite_i),
            .w_rd_i       (w_rd_i),
            .w_regwrite_i (w_regwrite_i),
            .sel_o        (sel_a)
        );

        hazard_fwd_sel #(.NUM_LANES(NUM_LANES)) u_fwd_b (
            .rs_i         (e_rs2_i[l*5 +: 5]),
            .m_rd_i       (m_rd_i),
            .m_regwrite_i (m_regwrite_i),
            .w_rd_i       (w_rd_i),
            .w_regwrite_i (w_regwrite_i),
            .sel_o        (sel_b)
        );

        assign fwd_a_o[l*FW +: FW] =
            {sel_a.valid, sel_a.stage, sel_a.lane[LANE_W-1:0]};
        assign fwd_b_o[l*FW +: FW] =
            {sel_b.valid, sel_b.stage, sel_b.lane[LANE_W-1:0]};

        if (LANE_W < MAX_LANE_W) begin : g_pad
            logic unused_lane;
            assign unused_lane = ^{sel_a.lane[MAX_LANE_W-1:LANE_W],
                                   sel_b.lane[MAX_LANE_W-1:LANE_W]};
        end
    end

    // Oldest redirecting lane kills every younger E lane
    always_comb begin
        logic found;
        found = 1'b0;
        kill  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (found) kill[i] = 1'b1;
            if (redirect_e_i[i]) found = 1'b1;
        end
        redir = found;
    end

    // Long writeback frees its register in the same cycle (write-first regfile)
    always_comb begin
        wb_clr = '0;
        if (long_wb_valid_i) wb_clr[long_wb_rd_i] = 1'b1;
        busy_vis = busy_q & ~wb_clr;
    end

    assign pending = d_valid_i & ~done_q;

    // Per D lane hazards: load-use, scoreboard RAW/WAW, older-lane RAW
    always_comb begin
        blocked   = '0;
        long_lane = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            logic [4:0] rs1;
            logic [4:0] rs2;
            logic [4:0] rd;
            rs1 = d_rs1_i[j*5 +: 5];
            rs2 = d_rs2_i[j*5 +: 5];
            rd  = d_rd_i[j*5 +: 5];
            long_lane[j] = d_long_i[j] & d_regwrite_i[j] & (rd != 5'd0);
            for (int e = 0; e < NUM_LANES; e++) begin
                if (e_load_i[e] && e_rd_i[e*5 +: 5] != 5'd0 &&
                    (e_rd_i[e*5 +: 5] == rs1 || e_rd_i[e*5 +: 5] == rs2))
                    blocked[j] = 1'b1;
            end
            if (busy_vis[rs1] || busy_vis[rs2] ||
                (d_regwrite_i[j] && busy_vis[rd]))
                blocked[j] = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (pending[i] && d_regwrite_i[i] &&
                    d_rd_i[i*5 +: 5] != 5'd0 &&
                    (d_rd_i[i*5 +: 5] == rs1 || d_rd_i[i*5 +: 5] == rs2))
                    blocked[j] = 1'b1;
            end
        end
    end

    // Contiguous issue prefix; long ops counted against the outstanding cap
    always_comb begin
        logic go;
        int   n_long;
        issue  = '0;
        go     = 1'b1;
        n_long = 0;
        for (int j = 0; j < NUM_LANES; j++) begin
            if (pending[j]) begin
                if (go && !blocked[j] &&
                    !(long_lane[j] && (int'(outst_q) + n_long >= MAX_LONG))) begin
                    issue[j] = 1'b1;
                    if (long_lane[j]) n_long = n_long + 1;
                end else begin
                    go = 1'b0;
                end
            end
        end
        if (redir) issue = '0;
    end

    assign stall          = !redir && ((pending & ~issue) != '0);
    assign issue_mask_o   = issue;
    assign stall_f_o      = stall;
    assign stall_d_o      = stall;
    assign flush_d_o      = redir;
    assign flush_e_o      = ~issue;
    assign flush_e_lane_o = kill;

    // Next state for the partial-bundle tracker
    always_comb begin
        state_n = state_q;
        done_n  = done_q;
        if (redir) begin
            state_n = S_FULL;
            done_n  = '0;
        end else begin
            unique case (state_q)
                S_FULL: begin
                    if (stall && issue != '0) begin
                        state_n = S_PART;
                        done_n  = issue;
                    end
                end
                S_PART: begin
                    if (!stall) begin
                        state_n = S_FULL;
                        done_n  = '0;
                    end else begin
                        done_n = done_q | issue;
                    end
                end
                default: begin
                    state_n = S_FULL;
                    done_n  = '0;
                end
            endcase
        end
    end

    // Partial-bundle tracker registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_FULL;
            done_q  <= '0;
        end else begin
            state_q <= state_n;
            done_q  <= done_n;
        end
    end

    // Scoreboard next value: sets win over clears, inc/dec net out
    always_comb begin
        logic [31:0] set;
        logic [31:0] clr;
        int          inc;
        int          dec;
        int          nxt;
        set = '0;
        clr = wb_clr;
        inc = 0;
        dec = long_wb_valid_i ? 1 : 0;
        for (int j = 0; j < NUM_LANES; j++) begin
            if (issue[j] && long_lane[j]) begin
                set[d_rd_i[j*5 +: 5]] = 1'b1;
                inc = inc + 1;
            end
        end
        if (redir) begin
            for (int e = 0; e < NUM_LANES; e++) begin
                if (kill[e] && e_long_i[e] && e_regwrite_i[e] &&
                    e_rd_i[e*5 +: 5] != 5'd0) begin
                    clr[e_rd_i[e*5 +: 5]] = 1'b1;
                    dec = dec + 1;
                end
            end
        end
        busy_n    = (busy_q & ~clr) | set;
        busy_n[0] = 1'b0;
        nxt       = int'(outst_q) + inc - dec;
        if (nxt < 0) nxt = 0;
        outst_n   = CNT_W'(nxt);
    end

    // Scoreboard registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            busy_q  <= '0;
            outst_q <= '0;
        end else begin
            busy_q  <= busy_n;
            outst_q <= outst_n;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_nlane.sv
// Directed bench for hazard_scoreboard_nlane (2 lanes, 4 long ops).
// Hand-computed expectations checked with immediate assertions.
module tb_hazard_scoreboard_nlane;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  d_valid, d_regwrite, d_long;
    logic [9:0]  d_rs1, d_rs2, d_rd;
    logic [9:0]  e_rs1, e_rs2, e_rd;
    logic [1:0]  e_regwrite, e_load, e_long;
    logic [9:0]  m_rd, w_rd;
    logic [1:0]  m_regwrite, w_regwrite;
    logic [1:0]  redirect;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [5:0]  fwd_a, fwd_b;
    logic [1:0]  issue, flush_e, flush_e_lane;
    logic        stall_f, stall_d, flush_d;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard_nlane #(.NUM_LANES(2), .MAX_LONG(4)) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .d_valid_i       (d_valid),
        .d_rs1_i         (d_rs1),
        .d_rs2_i         (d_rs2),
        .d_rd_i          (d_rd),
        .d_regwrite_i    (d_regwrite),
        .d_long_i        (d_long),
        .e_rs1_i         (e_rs1),
        .e_rs2_i         (e_rs2),
        .e_rd_i          (e_rd),
        .e_regwrite_i    (e_regwrite),
        .e_load_i        (e_load),
        .e_long_i        (e_long),
        .m_rd_i          (m_rd),
        .w_rd_i          (w_rd),
        .m_regwrite_i    (m_regwrite),
        .w_regwrite_i    (w_regwrite),
        .redirect_e_i    (redirect),
        .long_wb_valid_i (wb_valid),
        .long_wb_rd_i    (wb_rd),
        .fwd_a_o         (fwd_a),
        .fwd_b_o         (fwd_b),
        .issue_mask_o    (issue),
        .stall_f_o       (stall_f),
        .stall_d_o       (stall_d),
        .flush_d_o       (flush_d),
        .flush_e_o       (flush_e),
        .flush_e_lane_o  (flush_e_lane)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_all();
        d_valid = '0; d_regwrite = '0; d_long = '0;
        d_rs1 = '0; d_rs2 = '0; d_rd = '0;
        e_rs1 = '0; e_rs2 = '0; e_rd = '0;
        e_regwrite = '0; e_load = '0; e_long = '0;
        m_rd = '0; w_rd = '0; m_regwrite = '0; w_regwrite = '0;
        redirect = '0; wb_valid = 1'b0; wb_rd = '0;
    endtask

    task automatic set_d(input int l, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic lng);
        d_valid[l] = 1'b1;
        d_rs1[l*5 +: 5] = rs1;
        d_rs2[l*5 +: 5] = rs2;
        d_rd[l*5 +: 5] = rd;
        d_regwrite[l] = rw;
        d_long[l] = lng;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r);
        d_valid = '0;
        wb_valid = 1'b1;
        wb_rd = r;
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        clr_all();
        #12;
        chk("rst_issue", 32'(issue), 32'h0);
        chk("rst_flush_e", 32'(flush_e), 32'h3);
        chk("rst_stall", 32'({stall_f, stall_d, flush_d}), 32'h0);
        chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'h0);
        chk("rst_flane", 32'(flush_e_lane), 32'h0);
        tick();
        rstn = 1'b1;
        tick();

        // forwarding: M both lanes rd=5 -> youngest M lane
        e_rs1[5 +: 5] = 5'd5;
        m_rd = {5'd5, 5'd5}; m_regwrite = 2'b11;
        #1;
        chk("fwd_m_young", 32'(fwd_a[3 +: 3]), 32'b101);
        chk("fwd_lane0_zero", 32'(fwd_a[0 +: 3]), 32'b000);
        m_regwrite = 2'b00;
        w_rd = {5'd0, 5'd5}; w_regwrite = 2'b01;
        #1;
        chk("fwd_w0", 32'(fwd_a[3 +: 3]), 32'b110);
        m_rd = {5'd0, 5'd5}; m_regwrite = 2'b01;
        w_rd = {5'd5, 5'd0}; w_regwrite = 2'b10;
        #1;
        chk("fwd_m_over_w", 32'(fwd_a[3 +: 3]), 32'b100);
        e_rs1 = '0; m_rd = '0; m_regwrite = 2'b11;
        #1;
        chk("fwd_rs0", 32'(fwd_a), 32'h0);
        e_rs2[0 +: 5] = 5'd6; m_regwrite = '0;
        w_rd = {5'd6, 5'd6}; w_regwrite = 2'b11;
        #1;
        chk("fwd_b_w1", 32'(fwd_b[0 +: 3]), 32'b111);
        w_regwrite = 2'b00;
        #1;
        chk("fwd_b_norw", 32'(fwd_b[0 +: 3]), 32'b000);
        clr_all();

        // redirect on youngest lane kills nothing younger
        redirect = 2'b10;
        #1;
        chk("redir1_lane", 32'(flush_e_lane), 32'h0);
        chk("redir1_flushd", 32'(flush_d), 32'h1);
        redirect = 2'b11;
        #1;
        chk("redir_both_lane", 32'(flush_e_lane), 32'h2);
        clr_all();
        tick();

        // load-use on lane1 source
        e_load[0] = 1'b1; e_regwrite[0] = 1'b1; e_rd[0 +: 5] = 5'd7;
        set_d(0, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
        set_d(1, 5'd8, 5'd7, 5'd10, 1'b1, 1'b0);
        #1;
        chk("lu_issue", 32'(issue), 32'h1);
        chk("lu_stall", 32'({stall_f, stall_d}), 32'h3);
        chk("lu_flush_e", 32'(flush_e), 32'h2);
        tick();
        e_load = '0; e_rd[0 +: 5] = 5'd4;
        m_rd[0 +: 5] = 5'd7; m_regwrite[0] = 1'b1;
        #1;
        chk("lu_done_issue", 32'(issue), 32'h2);
        chk("lu_done_stall", 32'(stall_f), 32'h0);
        tick();
        clr_all();

        // intra-bundle RAW splits the bundle
        set_d(0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        set_d(1, 5'd3, 5'd0, 5'd11, 1'b1, 1'b0);
        #1;
        chk("raw_c1_issue", 32'(issue), 32'h1);
        chk("raw_c1_stall", 32'(stall_f), 32'h1);
        tick();
        chk("raw_c2_issue", 32'(issue), 32'h2);
        chk("raw_c2_stall", 32'(stall_f), 32'h0);
        tick();
        clr_all();

        // long op scoreboard: RAW and WAW on x9
        set_d(0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
        #1;
        chk("long_issue", 32'(issue), 32'h1);
        tick();
        clr_all();
        set_d(0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        #1;
        chk("waw_block", 32'(issue), 32'h0);
        chk("waw_stall", 32'(stall_f), 32'h1);
        clr_all();
        set_d(0, 5'd9, 5'd0, 5'd13, 1'b1, 1'b0);
        #1;
        chk("sb_raw_block", 32'(issue), 32'h0);
        tick();
        chk("sb_raw_hold", 32'(issue), 32'h0);
        wb_valid = 1'b1; wb_rd = 5'd9;
        #1;
        chk("sb_same_cycle", 32'(issue), 32'h1);
        chk("sb_same_stall", 32'(stall_f), 32'h0);
        tick();
        clr_all();

        // outstanding cap at MAX_LONG
        set_d(0, 5'd0, 5'd0, 5'd16, 1'b1, 1'b1);
        set_d(1, 5'd0, 5'd0, 5'd17, 1'b1, 1'b1);
        #1;
        chk("cap_b1", 32'(issue), 32'h3);
        tick();
        set_d(0, 5'd0, 5'd0, 5'd18, 1'b1, 1'b1);
        set_d(1, 5'd0, 5'd0, 5'd19, 1'b1, 1'b1);
        #1;
        chk("cap_b2", 32'(issue), 32'h3);
        tick();
        clr_all();
        set_d(0, 5'd0, 5'd0, 5'd20, 1'b1, 1'b1);
        #1;
        chk("cap_fifth_block", 32'(issue), 32'h0);
        chk("cap_fifth_stall", 32'(stall_f), 32'h1);
        tick();
        wb_valid = 1'b1; wb_rd = 5'd16;
        #1;
        chk("cap_wb_cycle", 32'(issue), 32'h0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("cap_fifth_go", 32'(issue), 32'h1);
        tick();
        clr_all();
        wb(5'd17);
        set_d(0, 5'd0, 5'd0, 5'd21, 1'b1, 1'b1);
        set_d(1, 5'd0, 5'd0, 5'd22, 1'b1, 1'b1);
        #1;
        chk("cap_split", 32'(issue), 32'h1);
        tick();
        wb_valid = 1'b1; wb_rd = 5'd18;
        #1;
        chk("cap_part_hold", 32'(issue), 32'h0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("cap_part_go", 32'(issue), 32'h2);
        chk("cap_part_stall", 32'(stall_f), 32'h0);
        tick();
        clr_all();
        wb(5'd19); wb(5'd20); wb(5'd21); wb(5'd22);

        // redirect while PART kills a long op in E lane1
        set_d(0, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0);
        set_d(1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1);
        #1;
        chk("rd_setup", 32'(issue), 32'h3);
        tick();
        clr_all();
        set_d(0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        set_d(1, 5'd3, 5'd0, 5'd23, 1'b1, 1'b0);
        #1;
        chk("rd_part", 32'(issue), 32'h1);
        tick();
        redirect = 2'b01;
        e_regwrite = 2'b11; e_long[1] = 1'b1;
        e_rd = {5'd12, 5'd3};
        #1;
        chk("rd_flane", 32'(flush_e_lane), 32'h2);
        chk("rd_flushd", 32'(flush_d), 32'h1);
        chk("rd_stall", 32'({stall_f, stall_d}), 32'h0);
        chk("rd_issue", 32'(issue), 32'h0);
        chk("rd_flush_e", 32'(flush_e), 32'h3);
        tick();
        clr_all();
        set_d(0, 5'd12, 5'd0, 5'd15, 1'b1, 1'b0);
        set_d(1, 5'd1, 5'd0, 5'd24, 1'b1, 1'b0);
        #1;
        chk("rd_after", 32'(issue), 32'h3);
        tick();
        clr_all();
        set_d(0, 5'd0, 5'd0, 5'd25, 1'b1, 1'b1);
        set_d(1, 5'd0, 5'd0, 5'd26, 1'b1, 1'b1);
        #1;
        chk("rd_cnt_a", 32'(issue), 32'h3);
        tick();
        set_d(0, 5'd0, 5'd0, 5'd27, 1'b1, 1'b1);
        set_d(1, 5'd0, 5'd0, 5'd28, 1'b1, 1'b1);
        #1;
        chk("rd_cnt_b", 32'(issue), 32'h3);
        tick();
        clr_all();

        // reset mid-PART abandons the partial bundle
        set_d(0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        set_d(1, 5'd3, 5'd0, 5'd11, 1'b1, 1'b0);
        tick();
        rstn = 1'b0;
        #1;
        chk("rst_part", 32'(issue), 32'h1);
        tick();
        rstn = 1'b1;
        #1;
        chk("rst_part_replay", 32'(issue), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_nlane.md
# hazard_scoreboard_nlane

N-lane generalisation of the superscalar hazard unit for the in-order RV32 core. It produces per-lane, per-operand forwarding selects for the E stage. It handles load-use stalls across all lanes and intra-bundle RAW dependencies by issuing a partial bundle and holding the rest. It also tracks long-latency results (mul/div) with a register scoreboard and an outstanding-op counter. It sits beside the decode/issue stage and drives all lane stall/flush controls.

## Interface
- NUM_LANES, 2, issue width; lane index = program order within a bundle (lane 0 oldest)
- MAX_LONG, 4, maximum outstanding long-latency ops
- LANE_W, $clog2(NUM_LANES) (min 1), derived
- clk_i  in  1  core clock
- rstn_i  in  1  reset; one clock; reset is asynchronous and active-low
- d_valid_i  in  NUM_LANES  D-stage lane holds a valid instruction
- d_rs1_i, d_rs2_i, d_rd_i  in  NUM_LANES×5  D-stage register indices
- d_regwrite_i, d_long_i  in  NUM_LANES  D writes rd / is long-latency
- e_rs1_i, e_rs2_i, e_rd_i  in  NUM_LANES×5  E-stage indices
- e_regwrite_i, e_load_i, e_long_i  in  NUM_LANES  E writes rd / is load / is long op
- m_rd_i, w_rd_i  in  NUM_LANES×5; m_regwrite_i, w_regwrite_i  in  NUM_LANES
- redirect_e_i  in  NUM_LANES  taken branch / jump resolved in E
- long_wb_valid_i  in  1; long_wb_rd_i  in  5  long unit writeback
- fwd_a_o, fwd_b_o  out  NUM_LANES×(2+LANE_W)  select {valid, stage (0=M, 1=W), lane}
- issue_mask_o  out  NUM_LANES  lanes moving D→E this cycle
- stall_f_o, stall_d_o  out  1  hold PC / hold D bundle
- flush_d_o  out  1; flush_e_o  out  NUM_LANES  bubble into E per lane
- flush_e_lane_o  out  NUM_LANES  kill E lanes younger than the redirecting lane

## Operation
- Forwarding, per E lane and operand: source 0 → no forward. Priority: M before W; within a stage, the highest-index (youngest) matching lane with regwrite. Hits require rd≠0.
- Load-use: any E lane with e_load_i whose rd≠0 matches an unissued D lane source → block that D lane.
- Scoreboard: busy[31:1]. Any unissued D lane whose rs1, rs2, or rd (WAW) is busy is blocked. busy[long_wb_rd_i] cleared by long_wb_valid_i. A cleared register is visible combinationally the same cycle (regfile is write-first).
- Long issue: blocked when outstanding == MAX_LONG. An issued long op with rd≠0 sets busy[rd] and increments outstanding; long_wb_valid_i decrements it.
- Intra-bundle: D lane j is blocked if any older unissued lane i<j in the same bundle has regwrite and rd≠0 matching j's rs1/rs2.
- Issue rule: issue_mask_o = the longest contiguous prefix of valid, not-yet-issued, unblocked lanes. A blocked lane blocks all younger lanes.
- FSM, FULL/PART, with done_mask register:
  - FULL→PART when 0 < popcount(issue) < remaining valid lanes; done_mask |= issue.
  - PART→FULL when all remaining lanes issue; done_mask cleared.
- stall_f_o = stall_d_o = bundle not fully issued this cycle. flush_e_o = ~issue_mask_o.
- Redirect, oldest asserting lane k:
  - flush_e_lane_o = lanes > k.
  - flush_d_o = 1; stall_f_o/stall_d_o forced 0; issue_mask_o = 0.
  - FSM→FULL, done_mask cleared.
  - Long ops in killed E lanes clear busy[e_rd] and decrement outstanding.
- Concurrent set and clear of the same busy bit: set wins. Concurrent outstanding inc and dec: net 0.

## Timing
- Forward selects, blocks, stalls and flushes are combinational (0-cycle).
- busy set / outstanding increment are visible the cycle after issue.
- Reset values:
  - State: busy=0, outstanding=0, FSM=FULL, done_mask=0.
  - Outputs with all inputs 0: fwd 0, issue_mask 0, stall_f/stall_d 0, flush_d 0, flush_e all ones, flush_e_lane 0.
- Reset mid-PART abandons the partial bundle. Fetch replays from its PC.

## Structure
- hazard_pkg: fwd_sel_t struct {valid, stage, lane}, FWD_STAGE_M/W constants, fsm_e enum.
- Sub-module hazard_fwd_sel: one instance per lane per operand. Priority encoder over M/W lane matches.

## Test plan
- Lane1 E rs1=5; M lane0 and lane1 both rd=5 → fwd_a[1]={1,M,1}. Only W lane0 rd=5 → {1,W,0}. rs1=0 → 0.
- E lane0 load rd=7, D lane1 rs2=7 → issue_mask=01, stall_f=1, flush_e[1]=1. Next cycle, load in M → issue completes.
- D lane0 rd=3, lane1 rs1=3 → cycle1 issue=01, PART; cycle2 issue=10, FULL, stall_f=0.
- Issue long rd=9, then D reads x9 → blocked until long_wb rd=9. Same-cycle release and issue.
- Issue 4 long ops, fifth long op stalled; one writeback → fifth issues next cycle.
- Redirect on lane0 in E while PART: flush_e_lane=10, flush_d=1, FSM→FULL. Flushed lane1 long op's busy bit is cleared.
